streaming_fifo_arbiter: RTL and testbench

Round-robin, packet-atomic arbiter that merges two AXI-Stream producers into the single write port of a `StreamingFIFO_*` instance. It reads the FIFO `count` output and starts a packet only when the FIFO has room for the whole packet. Once a packet starts, it always completes without stalling on FIFO space. The block sits directly upstream of the FIFO, and its `out_V_V` port connects to the FIFO `in0_V_V` port.

---
 rtl/streaming_fifo_arbiter.sv | 82 ++++++++
 tb/tb_streaming_fifo_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/streaming_fifo_arbiter.sv
// streaming_fifo_arbiter: round-robin packet-atomic merge of two AXI-Stream producers into one FIFO; STREAMING_FIFO_ARB_STATS_EN adds per-producer packet counters
module streaming_fifo_arbiter #(
  parameter int WIDTH = 16,
  parameter int PKT_WORDS = 8,
  parameter int FIFO_DEPTH = 4096,
  parameter int COUNT_W = 13
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [WIDTH-1:0]   in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  input  logic [WIDTH-1:0]   in1_V_V_TDATA,
  input  logic               in1_V_V_TVALID,
  output logic               in1_V_V_TREADY,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  input  logic [COUNT_W-1:0] fifo_count,
`ifdef STREAMING_FIFO_ARB_STATS_EN
  output logic [15:0]        pkt_count0,
  output logic [15:0]        pkt_count1,
`endif
  output logic [1:0]         grant,
  output logic               busy
);
  localparam int BW = $clog2(PKT_WORDS + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [COUNT_W:0] free;
  logic start, fire, done, pick;
  always_comb begin
    free = (COUNT_W+1)'(FIFO_DEPTH) - {1'b0, fifo_count};
    pick = last_q ? ~in0_V_V_TVALID : in1_V_V_TVALID;
    busy = state_q == BURST;
    grant = busy ? {sel_q, ~sel_q} : 2'b00;
    out_V_V_TDATA = busy ? (sel_q ? in1_V_V_TDATA : in0_V_V_TDATA) : '0;
    out_V_V_TVALID = busy & (sel_q ? in1_V_V_TVALID : in0_V_V_TVALID);
    in0_V_V_TREADY = busy & ~sel_q & out_V_V_TREADY;
    in1_V_V_TREADY = busy & sel_q & out_V_V_TREADY;
    fire = out_V_V_TVALID & out_V_V_TREADY;
    done = fire & (beat_q == BW'(PKT_WORDS - 1));
    start = ~busy & (free >= (COUNT_W+1)'(PKT_WORDS)) & (in0_V_V_TVALID | in1_V_V_TVALID);
    state_d = start ? BURST : done ? IDLE : state_q;
    sel_d = start ? pick : sel_q;
    last_d = start ? pick : last_q;
    beat_d = start ? '0 : fire ? beat_q + 1'b1 : beat_q;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      last_q <= 1'b1;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      beat_q <= beat_d;
    end
  end
`ifdef STREAMING_FIFO_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = cnt0_q + 16'(done & ~sel_q);
    cnt1_d = cnt1_q + 16'(done & sel_q);
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;
`endif
endmodule

// File: tb/tb_streaming_fifo_arbiter.sv
// tb_streaming_fifo_arbiter: directed and random checks of streaming_fifo_arbiter against a packet-level model
module tb_streaming_fifo_arbiter;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [15:0] d0 = '0, d1 = '0, out_data;
  logic v0 = 1'b1, v1 = 1'b1, r0, r1, out_valid, ordy = 1'b1;
  logic [12:0] fifo_count = '0;
  logic [1:0] grant;
  logic busy;
`ifdef STREAMING_FIFO_ARB_STATS_EN
  logic [15:0] pkt_count0, pkt_count1;
`endif
  int n_vec = 0, n_bad = 0;
  int m_own, m_prev, m_left, m_pkts;
  logic [15:0] m_cnt [2];
  bit seq_data = 1'b0;
  int owners[$];
  logic [15:0] got0[$];
  always #5 ap_clk = ~ap_clk;
  streaming_fifo_arbiter dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in0_V_V_TDATA(d0), .in0_V_V_TVALID(v0), .in0_V_V_TREADY(r0),
    .in1_V_V_TDATA(d1), .in1_V_V_TVALID(v1), .in1_V_V_TREADY(r1),
    .out_V_V_TDATA(out_data), .out_V_V_TVALID(out_valid), .out_V_V_TREADY(ordy),
    .fifo_count(fifo_count),
`ifdef STREAMING_FIFO_ARB_STATS_EN
    .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
`endif
    .grant(grant), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic ev, f;
    logic [15:0] ed;
    int o;
    #1;
    o = m_own;
    ev = (o == 0) ? v0 : (o == 1) ? v1 : 1'b0;
    ed = (o == 0) ? d0 : (o == 1) ? d1 : 16'h0;
    chk("busy", 32'(busy), 32'(o >= 0));
    chk("grant", 32'(grant), o < 0 ? 32'd0 : 32'(1 << o));
    chk("tvalid", 32'(out_valid), 32'(ev));
    chk("tready0", 32'(r0), 32'(o == 0 && ordy));
    chk("tready1", 32'(r1), 32'(o == 1 && ordy));
    chk("tdata", 32'(out_data), 32'(ed));
`ifdef STREAMING_FIFO_ARB_STATS_EN
    chk("pkt_count0", 32'(pkt_count0), 32'(m_cnt[0]));
    chk("pkt_count1", 32'(pkt_count1), 32'(m_cnt[1]));
`endif
    f = ev && ordy;
    if (f && o == 0) got0.push_back(out_data);
    if (ap_rst) begin
      m_own = -1; m_prev = 1; m_left = 0; m_cnt = '{16'h0, 16'h0};
    end else if (o < 0) begin
      if (4096 - int'(fifo_count) >= 8 && (v0 || v1)) begin
        m_own = ((m_prev == 0) ? v1 : v0) ? 1 - m_prev : m_prev;
        m_prev = m_own; m_left = 8;
        owners.push_back(m_own);
      end
    end else if (f) begin
      m_left--;
      if (m_left == 0) begin
        m_cnt[o]++; m_own = -1; m_pkts++;
      end
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    if (seq_data && f && o == 0) d0++;
    if (seq_data && f && o == 1) d1++;
  endtask
  initial begin
    @(negedge ap_clk);
    @(negedge ap_clk);
    m_own = -1; m_prev = 1; m_left = 0; m_pkts = 0; m_cnt = '{16'h0, 16'h0};
    repeat (3) cycle();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tvalid", 32'(out_valid), 32'd0);
    chk("rst_tready", 32'({r1, r0}), 32'd0);
    ap_rst = 1'b0; v1 = 1'b0; seq_data = 1'b1; d0 = 16'h1; got0 = {};
    repeat (10) cycle();
    chk("single_words", 32'(got0.size()), 32'd8);
    for (int i = 0; i < 8 && i < got0.size(); i++) chk("single_data", 32'(got0[i]), 32'(i + 1));
    chk("single_regrant", 32'(grant), 32'd1);
    ap_rst = 1'b1; cycle();
    ap_rst = 1'b0; v0 = 1'b1; v1 = 1'b1; seq_data = 1'b0; owners = {};
    repeat (36) begin
      d0 = 16'($urandom); d1 = 16'($urandom);
      cycle();
    end
    chk("alt_packets", 32'(owners.size()), 32'd4);
    for (int k = 0; k < owners.size(); k++) chk("alt_owner", 32'(owners[k]), 32'(k % 2));
    fifo_count = 13'd4089;
    repeat (12) cycle();
    chk("gate_hold", 32'(grant), 32'd0);
    fifo_count = 13'd4088;
    cycle();
    chk("gate_open", 32'(grant != 2'b00), 32'd1);
    fifo_count = '0; seq_data = 1'b1;
    repeat (3) cycle();
    ordy = 1'b0;
    repeat (3) cycle();
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_data", 32'(out_data), 32'(grant == 2'b10 ? d1 : d0));
    ordy = 1'b1;
    repeat (4) cycle();
    chk("bp_not_done", 32'(busy), 32'd1);
    cycle();
    chk("bp_done", 32'(busy), 32'd0);
    ap_rst = 1'b1; cycle();
    ap_rst = 1'b0; v0 = 1'b0; v1 = 1'b1;
    repeat (4) cycle();
    chk("mid_grant1", 32'(grant), 32'd2);
    ap_rst = 1'b1; cycle();
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    ap_rst = 1'b0; v0 = 1'b1;
    cycle();
    chk("mid_first_grant", 32'(grant), 32'd1);
`ifdef STREAMING_FIFO_ARB_STATS_EN
    ap_rst = 1'b1; cycle();
    ap_rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
    repeat (27) cycle();
    chk("stats_count0", 32'(pkt_count0), 32'd2);
    chk("stats_count1", 32'(pkt_count1), 32'd1);
`endif
    seq_data = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      v0 = $urandom_range(0, 3) != 0;
      v1 = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      d0 = 16'($urandom); d1 = 16'($urandom);
      case ($urandom_range(0, 3))
        0: fifo_count = 13'd4088;
        1: fifo_count = 13'd4089;
        2: fifo_count = 13'($urandom_range(0, 4096));
        default: fifo_count = '0;
      endcase
      ap_rst = $urandom_range(0, 199) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
